dual_ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared `dual_ram` (one write port, one read port, 1-cycle registered read). Two masters share the RAM: m0, instruction fetch, and m1, load/store. Each master issues one read or write per cycle. The block arbitrates the write port and the read port independently with per-port round-robin, returns read data with a per-master valid, and resolves same-cycle read/write address collisions. It sits between the core's memory masters and the `dual_ram` instance.

---
 rtl/dual_ram_arbiter_if.sv | 56 +++++
 rtl/dual_ram_arbiter.sv | 101 ++++++++++
 tb/tb_dual_ram_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dual_ram_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : dual_ram_arbiter_if
// Brief   : Master-side request/grant/return bus plus dual_ram port bundle.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dual_ram_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 12
);
  logic          m0_req_i;
  logic          m1_req_i;
  logic          m0_we_i;
  logic          m1_we_i;
  logic [AW-1:0] m0_addr_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m0_wdata_i;
  logic [DW-1:0] m1_wdata_i;
  logic          m0_gnt_o;
  logic          m1_gnt_o;
  logic          m0_rvalid_o;
  logic          m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o;
  logic [DW-1:0] m1_rdata_o;
  logic          ram_w_en_o;
  logic [AW-1:0] ram_w_addr_o;
  logic [DW-1:0] ram_w_data_o;
  logic          ram_r_en_o;
  logic [AW-1:0] ram_r_addr_o;
  logic [DW-1:0] ram_r_data_i;

  // Arbiter side
  modport slave (
    input  m0_req_i, m1_req_i, m0_we_i, m1_we_i,
    input  m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
    output m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
    output m0_rdata_o, m1_rdata_o,
    output ram_w_en_o, ram_w_addr_o, ram_w_data_o,
    output ram_r_en_o, ram_r_addr_o,
    input  ram_r_data_i
  );

  // Core masters and RAM side
  modport master (
    output m0_req_i, m1_req_i, m0_we_i, m1_we_i,
    output m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
    input  m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
    input  m0_rdata_o, m1_rdata_o,
    input  ram_w_en_o, ram_w_addr_o, ram_w_data_o,
    input  ram_r_en_o, ram_r_addr_o,
    output ram_r_data_i
  );
endinterface

`default_nettype wire

// File: rtl/dual_ram_arbiter.sv
//------------------------------------------------------------------------------
// Module  : dual_ram_arbiter
// Brief   : Two-master round-robin arbiter for dual_ram write/read ports with
//           read-after-write collision handling. Option macro: RAW_BYPASS_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dual_ram_arbiter #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic                clk,
  input  logic                rst,
  dual_ram_arbiter_if.slave   bus
);

  logic          w_wr0, w_wr1, w_rd0, w_rd1;
  logic          w_wany, w_rany;
  logic          w_wsel, w_rsel;         // 0 selects m0, 1 selects m1
  logic [AW-1:0] w_waddr, w_raddr;
  logic [DW-1:0] w_wdata;
  logic          w_coll;
  logic          w_wgo, w_rgo;
  logic          w_rv0, w_rv1;
  logic [DW-1:0] w_ret;

  logic          r_wr_pri, r_rd_pri;
  logic          r_pend, r_tag, r_byp;
  logic [DW-1:0] r_byp_data;
  logic [DW-1:0] r_m0_rdata, r_m1_rdata;

  assign w_wr0 = bus.m0_req_i &  bus.m0_we_i;
  assign w_wr1 = bus.m1_req_i &  bus.m1_we_i;
  assign w_rd0 = bus.m0_req_i & ~bus.m0_we_i;
  assign w_rd1 = bus.m1_req_i & ~bus.m1_we_i;

  always_comb begin
    w_wany  = w_wr0 | w_wr1;
    w_rany  = w_rd0 | w_rd1;
    w_wsel  = (w_wr0 & w_wr1) ? r_wr_pri : w_wr1;
    w_rsel  = (w_rd0 & w_rd1) ? r_rd_pri : w_rd1;
    w_waddr = w_wsel ? bus.m1_addr_i  : bus.m0_addr_i;
    w_wdata = w_wsel ? bus.m1_wdata_i : bus.m0_wdata_i;
    w_raddr = w_rsel ? bus.m1_addr_i  : bus.m0_addr_i;
    w_coll  = w_wany & w_rany & (w_waddr == w_raddr);
    w_wgo   = w_wany & ~rst;
`ifdef RAW_BYPASS_EN
    w_rgo   = w_rany & ~rst;
`else
    // A colliding read waits a cycle so the RAM returns the freshly written word
    w_rgo   = w_rany & ~w_coll & ~rst;
`endif
  end

  assign bus.m0_gnt_o = (w_wgo & ~w_wsel) | (w_rgo & ~w_rsel);
  assign bus.m1_gnt_o = (w_wgo &  w_wsel) | (w_rgo &  w_rsel);

  assign bus.ram_w_en_o   = w_wgo;
  assign bus.ram_w_addr_o = w_waddr;
  assign bus.ram_w_data_o = w_wdata;
  assign bus.ram_r_en_o   = w_rgo;
  assign bus.ram_r_addr_o = w_raddr;

  // Reset in the return cycle cancels an in-flight read
  assign w_rv0 = r_pend & ~r_tag & ~rst;
  assign w_rv1 = r_pend &  r_tag & ~rst;
  assign w_ret = r_byp ? r_byp_data : bus.ram_r_data_i;

  assign bus.m0_rvalid_o = w_rv0;
  assign bus.m1_rvalid_o = w_rv1;
  assign bus.m0_rdata_o  = w_rv0 ? w_ret : r_m0_rdata;
  assign bus.m1_rdata_o  = w_rv1 ? w_ret : r_m1_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_pri   <= 1'b0;
      r_rd_pri   <= 1'b0;
      r_pend     <= 1'b0;
      r_tag      <= 1'b0;
      r_byp      <= 1'b0;
      r_byp_data <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      if (w_wgo) r_wr_pri <= ~w_wsel;
      if (w_rgo) r_rd_pri <= ~w_rsel;
      r_pend <= w_rgo;
      if (w_rgo) begin
        r_tag <= w_rsel;
        r_byp <= w_coll;
      end
      if (w_rgo && w_coll) r_byp_data <= w_wdata;
      if (w_rv0) r_m0_rdata <= w_ret;
      if (w_rv1) r_m1_rdata <= w_ret;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dual_ram_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_dual_ram_arbiter
// Brief   : Directed self-checking bench for dual_ram_arbiter with a RAM model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dual_ram_arbiter;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;

  dual_ram_arbiter_if #(.DW(32), .AW(12)) bus ();

  dual_ram_arbiter #(.DW(32), .AW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual_ram: unwritten words read as {20'hC0DE0, addr}
  logic [31:0] mem  [0:4095];
  bit          seen [0:4095];
  always @(posedge clk) begin
    if (bus.ram_w_en_o) begin
      mem[bus.ram_w_addr_o]  <= bus.ram_w_data_o;
      seen[bus.ram_w_addr_o] <= 1'b1;
    end
    if (bus.ram_r_en_o)
      bus.ram_r_data_i <= seen[bus.ram_r_addr_o] ? mem[bus.ram_r_addr_o]
                                                 : {20'hC0DE0, bus.ram_r_addr_o};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic req, input logic we, input logic [11:0] addr, input logic [31:0] wd);
    bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr; bus.m0_wdata_i = wd;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [11:0] addr, input logic [31:0] wd);
    bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr; bus.m1_wdata_i = wd;
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1;
    drv0(1'b0, 1'b0, 12'h0, 32'h0);
    drv1(1'b0, 1'b0, 12'h0, 32'h0);
    tick();
    tick();

    // Grants and enables are suppressed while reset is high
    drv0(1'b1, 1'b1, 12'h7, 32'h77);
    drv1(1'b1, 1'b0, 12'h8, 32'h0);
    #1;
    check("rst_m0_gnt", bus.m0_gnt_o, 0);
    check("rst_m1_gnt", bus.m1_gnt_o, 0);
    check("rst_w_en", bus.ram_w_en_o, 0);
    check("rst_r_en", bus.ram_r_en_o, 0);
    drv0(1'b0, 1'b0, 12'h0, 32'h0);
    drv1(1'b0, 1'b0, 12'h0, 32'h0);
    tick();
    check("rst_m0_rvalid", bus.m0_rvalid_o, 0);
    check("rst_m1_rvalid", bus.m1_rvalid_o, 0);
    check("rst_m0_rdata", bus.m0_rdata_o, 0);
    check("rst_m1_rdata", bus.m1_rdata_o, 0);
    rst = 1'b0;

    // Write contention right after reset: m0 first, then m1
    drv0(1'b1, 1'b1, 12'h001, 32'h11);
    drv1(1'b1, 1'b1, 12'h002, 32'h22);
    #1;
    check("wc0_m0_gnt", bus.m0_gnt_o, 1);
    check("wc0_m1_gnt", bus.m1_gnt_o, 0);
    check("wc0_w_addr", bus.ram_w_addr_o, 12'h001);
    check("wc0_w_data", bus.ram_w_data_o, 32'h11);
    tick();
    drv0(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    check("wc1_m1_gnt", bus.m1_gnt_o, 1);
    check("wc1_w_addr", bus.ram_w_addr_o, 12'h002);
    tick();
    drv1(1'b0, 1'b0, 12'h0, 32'h0);

    // Sustained read contention for six cycles, alternating from m0
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        drv0(1'b1, 1'b0, 12'h001, 32'h0);
        drv1(1'b1, 1'b0, 12'h002, 32'h0);
      end else begin
        drv0(1'b0, 1'b0, 12'h0, 32'h0);
        drv1(1'b0, 1'b0, 12'h0, 32'h0);
      end
      #1;
      if (i < 6) begin
        check($sformatf("rc%0d_m0_gnt", i), bus.m0_gnt_o, (i % 2 == 0) ? 1 : 0);
        check($sformatf("rc%0d_m1_gnt", i), bus.m1_gnt_o, (i % 2 == 1) ? 1 : 0);
      end
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          check($sformatf("rc%0d_m0_rvalid", i), bus.m0_rvalid_o, 1);
          check($sformatf("rc%0d_m1_rvalid", i), bus.m1_rvalid_o, 0);
          check($sformatf("rc%0d_m0_rdata", i), bus.m0_rdata_o, 32'h11);
        end else begin
          check($sformatf("rc%0d_m1_rvalid", i), bus.m1_rvalid_o, 1);
          check($sformatf("rc%0d_m0_rvalid", i), bus.m0_rvalid_o, 0);
          check($sformatf("rc%0d_m1_rdata", i), bus.m1_rdata_o, 32'h22);
        end
      end
      tick();
    end
    check("rc_m1_rvalid_drop", bus.m1_rvalid_o, 0);

    // Single write then read of the same word
    drv0(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
    #1;
    check("wr_m0_gnt", bus.m0_gnt_o, 1);
    tick();
    drv0(1'b1, 1'b0, 12'h010, 32'h0);
    #1;
    check("rd_m0_gnt", bus.m0_gnt_o, 1);
    check("rd_r_en", bus.ram_r_en_o, 1);
    tick();
    drv0(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    check("rd_m0_rvalid", bus.m0_rvalid_o, 1);
    check("rd_m0_rdata", bus.m0_rdata_o, 32'hDEADBEEF);
    tick();

    // Parallel ports: m0 reads 0x020 while m1 writes 0x030
    drv0(1'b1, 1'b0, 12'h020, 32'h0);
    drv1(1'b1, 1'b1, 12'h030, 32'h5);
    #1;
    check("par_m0_gnt", bus.m0_gnt_o, 1);
    check("par_m1_gnt", bus.m1_gnt_o, 1);
    check("par_w_en", bus.ram_w_en_o, 1);
    check("par_r_en", bus.ram_r_en_o, 1);
    tick();
    drv0(1'b0, 1'b0, 12'h0, 32'h0);
    drv1(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    check("par_m0_rvalid", bus.m0_rvalid_o, 1);
    check("par_m0_rdata", bus.m0_rdata_o, 32'hC0DE0020);
    tick();

    // Read/write collision on 0x005
    drv0(1'b1, 1'b1, 12'h005, 32'hA5A5A5A5);
    drv1(1'b1, 1'b0, 12'h005, 32'h0);
    #1;
    check("col_m0_gnt", bus.m0_gnt_o, 1);
`ifdef RAW_BYPASS_EN
    check("col_m1_gnt", bus.m1_gnt_o, 1);
    tick();
    drv0(1'b0, 1'b0, 12'h0, 32'h0);
    drv1(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    check("col_m1_rvalid", bus.m1_rvalid_o, 1);
    check("col_m1_rdata", bus.m1_rdata_o, 32'hA5A5A5A5);
`else
    check("col_m1_gnt", bus.m1_gnt_o, 0);
    check("col_r_en", bus.ram_r_en_o, 0);
    tick();
    drv0(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    check("col1_m1_gnt", bus.m1_gnt_o, 1);
    check("col1_m1_rvalid", bus.m1_rvalid_o, 0);
    tick();
    drv1(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    check("col_m1_rvalid", bus.m1_rvalid_o, 1);
    check("col_m1_rdata", bus.m1_rdata_o, 32'hA5A5A5A5);
`endif
    check("col_m0_rdata_hold", bus.m0_rdata_o, 32'hC0DE0020);
    tick();

    // Reset the cycle after an m1 read grant
    drv1(1'b1, 1'b0, 12'h002, 32'h0);
    #1;
    check("rmr_m1_gnt", bus.m1_gnt_o, 1);
    tick();
    drv1(1'b0, 1'b0, 12'h0, 32'h0);
    rst = 1'b1;
    #1;
    check("rmr_m1_rvalid_rst", bus.m1_rvalid_o, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rmr_m1_rvalid", bus.m1_rvalid_o, 0);
    check("rmr_m1_rdata", bus.m1_rdata_o, 0);
    check("rmr_m0_rdata", bus.m0_rdata_o, 0);
    drv0(1'b1, 1'b1, 12'h040, 32'h1);
    drv1(1'b1, 1'b1, 12'h041, 32'h2);
    #1;
    check("rmr_m0_wins", bus.m0_gnt_o, 1);
    check("rmr_m1_loses", bus.m1_gnt_o, 0);
    tick();
    drv0(1'b0, 1'b0, 12'h0, 32'h0);
    drv1(1'b0, 1'b0, 12'h0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
